// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed NDIGITS-digit 7-segment driver.
// Holds one {sym, dp, blink} register per digit, scans the digits one slot
// at a time, decodes 6-bit symbol codes to segments and applies blink.
module seg7_scan_ctrl #(
    parameter int NDIGITS      = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 100,
    parameter int AW           = $clog2(NDIGITS)
) (
    input  logic               clk_2,
    input  logic               reset_n,
    input  logic               en,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [5:0]         wr_sym,
    input  logic               wr_dp,
    input  logic               wr_blink,
    output logic [7:0]         SEG,
    output logic [NDIGITS-1:0] AN,
    output logic               frame_done
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NDIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    // Symbol code -> segments {g,f,e,d,c,b,a}; codes 42..63 are blank
    function automatic logic [6:0] decode(input logic [5:0] s);
        logic [6:0] r;
        case (s)
            6'd0:  r = 7'h3f;  6'd1:  r = 7'h06;  6'd2:  r = 7'h5b;  6'd3:  r = 7'h4f;
            6'd4:  r = 7'h66;  6'd5:  r = 7'h6d;  6'd6:  r = 7'h7d;  6'd7:  r = 7'h07;
            6'd8:  r = 7'h7f;  6'd9:  r = 7'h6f;  6'd10: r = 7'h77;  6'd11: r = 7'h7c;
            6'd12: r = 7'h39;  6'd13: r = 7'h5e;  6'd14: r = 7'h79;  6'd15: r = 7'h71;
            6'd16: r = 7'h77;  6'd17: r = 7'h7c;  6'd18: r = 7'h39;  6'd19: r = 7'h58;
            6'd20: r = 7'h5e;  6'd21: r = 7'h79;  6'd22: r = 7'h71;  6'd23: r = 7'h6f;
            6'd24: r = 7'h76;  6'd25: r = 7'h74;  6'd26: r = 7'h10;  6'd27: r = 7'h06;
            6'd28: r = 7'h1e;  6'd29: r = 7'h38;  6'd30: r = 7'h54;  6'd31: r = 7'h3f;
            6'd32: r = 7'h5c;  6'd33: r = 7'h73;  6'd34: r = 7'h67;  6'd35: r = 7'h50;
            6'd36: r = 7'h6d;  6'd37: r = 7'h78;  6'd38: r = 7'h3e;  6'd39: r = 7'h1c;
            6'd40: r = 7'h6e;  6'd41: r = 7'h63;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    logic [NDIGITS-1:0][5:0] sym_q, sym_d;
    logic [NDIGITS-1:0]      dp_q, dp_d;
    logic [NDIGITS-1:0]      blink_q, blink_d;
    logic [DW-1:0]           div_q, div_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           frm_q, frm_d;
    logic                    ph_q, ph_d;
    logic [7:0]              seg_q, seg_d;
    logic [NDIGITS-1:0]      an_q, an_d;
    logic                    fd_q, fd_d;
    logic                    wrap;

    // Digit register write port; out-of-range addresses are dropped
    always_comb begin
        sym_d   = sym_q;
        dp_d    = dp_q;
        blink_d = blink_q;
        if (wr_en && (int'(wr_addr) < NDIGITS)) begin
            sym_d[wr_addr]   = wr_sym;
            dp_d[wr_addr]    = wr_dp;
            blink_d[wr_addr] = wr_blink;
        end
    end

    // Slot divider, digit index, frame counter and blink phase; all hold when en=0
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        frm_d = frm_q;
        ph_d  = ph_q;
        wrap  = 1'b0;
        if (en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                    if (frm_q == FRM_LAST) begin
                        frm_d = '0;
                        ph_d  = ~ph_q;
                    end else begin
                        frm_d = frm_q + 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Next output word: selected digit is driven from current idx and digit regs,
    // so a write or advance at one edge shows at the following edge
    always_comb begin
        an_d  = '0;
        seg_d = '0;
        fd_d  = 1'b0;
        if (en) begin
            an_d[idx_q] = 1'b1;
            if (!(blink_q[idx_q] && ph_q))
                seg_d = {dp_q[idx_q], decode(sym_q[idx_q])};
            fd_d = wrap;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            sym_q   <= {NDIGITS{6'd63}};
            dp_q    <= '0;
            blink_q <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            frm_q   <= '0;
            ph_q    <= 1'b0;
            seg_q   <= '0;
            an_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            sym_q   <= sym_d;
            dp_q    <= dp_d;
            blink_q <= blink_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            ph_q    <= ph_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: NDIGITS=4 main instance plus an
// NDIGITS=3 instance for the out-of-range address case.
module tb_seg7_scan_ctrl;
    logic       clk_2 = 1'b0;
    logic       reset_n, en, wr_en, wr_dp, wr_blink;
    logic [1:0] wr_addr;
    logic [5:0] wr_sym;
    logic [7:0] SEG, SEG3;
    logic [3:0] AN;
    logic [2:0] AN3;
    logic       frame_done, frame_done3;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk_2 = ~clk_2;

    seg7_scan_ctrl #(.NDIGITS(4), .SCAN_DIV(3), .BLINK_FRAMES(2)) u_dut (
        .clk_2(clk_2), .reset_n(reset_n), .en(en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_sym(wr_sym), .wr_dp(wr_dp), .wr_blink(wr_blink),
        .SEG(SEG), .AN(AN), .frame_done(frame_done));

    seg7_scan_ctrl #(.NDIGITS(3), .SCAN_DIV(3), .BLINK_FRAMES(2)) u_dut3 (
        .clk_2(clk_2), .reset_n(reset_n), .en(en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_sym(wr_sym), .wr_dp(wr_dp), .wr_blink(wr_blink),
        .SEG(SEG3), .AN(AN3), .frame_done(frame_done3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [5:0] s, input logic d, input logic b);
        wr_en = 1'b1; wr_addr = a; wr_sym = s; wr_dp = d; wr_blink = b;
        tick();
        wr_en = 1'b0;
    endtask

    // Expected AN for the k-th edge after reset release (k starts at 1)
    function automatic logic [3:0] exp_an(input int k);
        return 4'b0001 << (((k - 1) / 3) % 4);
    endfunction

    initial begin
        logic [3:0] prev;
        bit         found;
        reset_n = 1'b0; en = 1'b1; wr_en = 1'b0;
        wr_addr = '0; wr_sym = '0; wr_dp = 1'b0; wr_blink = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_an", AN, 4'b0000);
        chk("rst_seg", SEG, 8'h00);
        chk("rst_fd", frame_done, 1'b0);

        // two blank frames: AN sequence, SEG dark, frame_done on wrap only
        reset_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk("scan_an", AN, exp_an(k));
            chk("scan_seg", SEG, 8'h00);
            chk("scan_fd", frame_done, (k % 12) == 0);
        end

        // writes: d2=A+dp, d1=degree, d0=blank code 50, addr 3 (=8+dp)
        wr(2'd2, 6'd10, 1'b1, 1'b0);
        wr(2'd1, 6'd41, 1'b0, 1'b0);
        wr(2'd0, 6'd50, 1'b0, 1'b0);
        wr(2'd3, 6'd8,  1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            case (AN)
                4'b0001: chk("seg_d0_blank", SEG, 8'h00);
                4'b0010: chk("seg_d1_deg",   SEG, 8'h63);
                4'b0100: chk("seg_d2_A_dp",  SEG, 8'hf7);
                4'b1000: chk("seg_d3_8_dp",  SEG, 8'hff);
                default: chk("an_onehot",    AN,  4'b0001);
            endcase
            case (AN3)
                3'b001:  chk("n3_seg_d0", SEG3, 8'h00);
                3'b010:  chk("n3_seg_d1", SEG3, 8'h63);
                3'b100:  chk("n3_seg_d2", SEG3, 8'hf7);
                default: chk("n3_an_onehot", AN3, 3'b001);
            endcase
        end

        // en drop mid-slot: wait for first cycle of the digit-2 slot
        prev = AN; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (AN == 4'b0100 && prev != 4'b0100) found = 1'b1;
            prev = AN;
        end
        chk("wait_slot2", found, 1'b1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("en0_an", AN, 4'b0000);
            chk("en0_seg", SEG, 8'h00);
            chk("en0_fd", frame_done, 1'b0);
        end
        en = 1'b1;
        tick(); chk("resume_an1", AN, 4'b0100); chk("resume_seg1", SEG, 8'hf7);
        tick(); chk("resume_an2", AN, 4'b0100);
        tick(); chk("resume_an3", AN, 4'b1000);

        // reset mid-frame with a write pending: write lost, all blank
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd2; wr_sym = 6'd5; wr_dp = 1'b1;
        tick();
        chk("rstw_an", AN, 4'b0000);
        chk("rstw_seg", SEG, 8'h00);
        reset_n = 1'b1; wr_en = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rstw_scan_an", AN, exp_an(k));
            chk("rstw_scan_seg", SEG, 8'h00);
        end

        // blink: d3 = 7 with blink, written on the release edge
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd3; wr_sym = 6'd7; wr_dp = 1'b0; wr_blink = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            tick();
            wr_en = 1'b0;
            chk("blk_an", AN, exp_an(k));
            if (exp_an(k) == 4'b1000) begin
                if (((k - 1) / 12) == 2 || ((k - 1) / 12) == 3)
                    chk("blk_seg_off", SEG, 8'h00);
                else
                    chk("blk_seg_on", SEG, 8'h07);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Multiplexed driver for an `NDIGITS`-digit common-bus 7-segment display.
- Holds one symbol register per digit, written through a simple write port.
- Time-multiplexes the digits by scanning them.
- Decodes a 6-bit symbol code into segment patterns: 16 hex glyphs, 26 letter/degree glyphs, and blank.
- Supports a per-digit decimal point and per-digit blink.

It sits between the board-top switch/datapath logic and the `SEG`/digit-enable pins. It replaces direct single-digit combinational decoding.

## Interface
- `NDIGITS`, 4: number of digits scanned (≥2).
- `SCAN_DIV`, 50000: clock cycles each digit stays enabled (≥2).
- `BLINK_FRAMES`, 100: complete scan frames per blink half-period (≥1).
- `AW`, `$clog2(NDIGITS)`: write address width (derived, not overridden).

Ports:
- `clk_2`, in, 1: the single clock; all state changes on its rising edge.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: 1 means scanning runs; 0 means display dark and counters frozen.
- `wr_en`, in, 1: write strobe, sampled each edge.
- `wr_addr`, in, AW: digit index to write (0 is rightmost).
- `wr_sym`, in, 6: symbol code.
- `wr_dp`, in, 1: decimal point for that digit.
- `wr_blink`, in, 1: blink enable for that digit.
- `SEG`, out, 8: segments {dp,g,f,e,d,c,b,a}, active-high, registered.
- `AN`, out, NDIGITS: one-hot digit enable, active-high, registered.
- `frame_done`, out, 1: one-cycle pulse when the last digit's slot ends.

## Operation
- Per-digit state: `sym[5:0]`, `dp`, `blink`.
- Write:
  - On an edge with `wr_en=1` and `wr_addr<NDIGITS`, digit `wr_addr` loads {`wr_sym`,`wr_dp`,`wr_blink`}.
  - `wr_addr≥NDIGITS` is ignored; no state changes.
- Symbol decode (segment bits [6:0], hex):
  - Codes 0–15: 3f 06 5b 4f 66 6d 7d 07 7f 6f 77 7c 39 5e 79 71 (0–9, A, b, C, d, E, F).
  - Codes 16–41: 77 7c 39 58 5e 79 71 6f 76 74 10 06 1e 38 54 3f 5c 73 67 50 6d 78 3e 1c 6e 63 (A b C c d E F g H h i I J L n O o P q r S t U v y °).
  - Codes 42–63: 00 (blank).
- Scan state: `div_cnt` counts 0..SCAN_DIV-1; `idx` counts 0..NDIGITS-1.
  - When `div_cnt=SCAN_DIV-1`, `div_cnt` wraps to 0 and `idx` advances.
  - `idx` wraps from NDIGITS-1 to 0.
  - When `idx` wraps, `frame_done` pulses for that same cycle.
- Blink: `frm_cnt` counts frames 0..BLINK_FRAMES-1. When it wraps, `blink_ph` toggles.
- Output register, each edge while `en=1`:
  - `AN` is one-hot at `idx`.
  - `SEG` is {dp, decode(sym)} of digit `idx`.
  - `SEG` is forced to 0 when that digit has `blink=1` and `blink_ph=1`. `AN` is still asserted in this case.
- `en=0`:
  - `AN`=0 and `SEG`=0 from the next edge.
  - `div_cnt`, `idx`, `frm_cnt` and `blink_ph` hold their values.
  - Writes still accepted.
- Reset (`reset_n=0` at an edge), which overrides writes and `en`:
  - Every digit: sym=63 (blank), dp=0, blink=0.
  - Counters 0, `blink_ph`=0.
  - `AN`=0, `SEG`=0, `frame_done`=0.

## Timing
- Write-to-display latency:
  - A write at edge E updates the digit registers at E.
  - If that digit is currently selected, `SEG` reflects it at edge E+1.
  - Otherwise `SEG` reflects it in the digit's next slot.
- A write and a scan advance on the same edge do not interfere. The output at E+1 uses the post-write register contents and the post-advance `idx`.
- First output after reset release (with `en=1`): `AN`=1 (digit 0) on the first edge with `reset_n=1`.
- Slot durations:
  - Each digit is enabled for exactly SCAN_DIV cycles.
  - A frame is NDIGITS·SCAN_DIV cycles.
  - A blink half-period is BLINK_FRAMES frames.
- `AN` is never multi-hot. `AN` changes on the same edge as `SEG`; there is no skew between them.
- Reset mid-slot: the next edge with `reset_n=1` restarts at digit 0 with a full SCAN_DIV slot.

## Test plan
- Bench parameters: NDIGITS=4, SCAN_DIV=3, BLINK_FRAMES=2.
- Reset then `en=1`:
  - `AN` sequence is 0001×3, 0010×3, 0100×3, 1000×3, then repeats.
  - All `SEG`=00.
  - `frame_done` high only on the cycle `idx` wraps 3→0.
- Write digit2 = {sym 10, dp 1}: during the `AN`=0100 slot, `SEG`=F7.
- Write digit1 with `wr_sym`=41 ("°"): `SEG`=63 in its slot.
- Write digit0 with sym=50 (any code 42–63): `SEG`=00 in its slot.
- Write `wr_addr` out of range: no effect at NDIGITS=4 where 4 values are all valid. At NDIGITS=3, `wr_addr`=3 must leave all digits unchanged.
- Blink test: digit3 = {sym 7, blink 1}.
  - Frames 0–1: `SEG`=07 in its slot.
  - Frames 2–3: `SEG`=00 with `AN`=1000 still asserted.
  - Frames 4–5: `SEG`=07 again.
- Enable and reset interaction:
  - Drop `en` for 5 cycles mid-slot: `AN`/`SEG`=0 throughout.
  - Resume with the same `idx` and the remaining slot count.
  - Assert `reset_n=0` mid-frame with `wr_en=1`: the write is lost and all digits are blank.
